mask_bank: RTL and testbench
============================

# mask_bank

Parametrised trigger-mask register bank for the logic analyzer: NUM_MASKS masks of MASK_WIDTH bits, loaded byte-by-byte from the host command decoder. Each mask is double-buffered. Byte writes land in a shadow copy. A commit handshake copies all shadows to the active copies atomically, and the copy is deferred while a capture is running, so the trigger comparator never sees a half-written mask. The block sits between the command decoder (P0/P1/P2 byte protocol) and the trigger/compare logic.

## Interface
- NUM_MASKS, 5: number of masks; 1..256.
- MASK_WIDTH, 64: bits per mask; a multiple of 8, 8..2048.
- in_clk  input  1  sole clock; all state changes on the rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_we  input  1  byte write strobe, one write per cycle high.
- in_P0  input  8  mask index.
- in_P1  input  8  byte index within the mask; byte 0 = bits [7:0].
- in_P2  input  8  write data.
- in_commit  input  1  commit request; single-cycle pulse or level, sampled each cycle.
- in_busy  input  1  capture in progress; defers commits.
- in_err_clr  input  1  clears out_err.
- in_rd_en  input  1  shadow readback request, addressed by in_P0/in_P1.
- out_masks  output  NUM_MASKS*MASK_WIDTH  active masks, flattened; mask i = bits [i*MASK_WIDTH +: MASK_WIDTH].
- out_commit_pending  output  1  high while a commit is waiting on in_busy.
- out_commit_done  output  1  one-cycle pulse; active masks updated.
- out_err  output  1  sticky out-of-range access flag.
- out_rd_data  output  8  readback byte.
- out_rd_valid  output  1  readback strobe.

## Operation
- Reset values, for shadow and active copies: mask 0 all ones, all other masks zero.
- Reset values, for the outputs: out_commit_pending=0, out_commit_done=0, out_err=0, out_rd_data=0x00, out_rd_valid=0.
- Reset, for the FSM: the FSM goes to IDLE.
- Write: when in_we is high and in_P0<NUM_MASKS and in_P1<MASK_WIDTH/8, the shadow byte [in_P0][in_P1] is set to in_P2.
- The active copies never change on a write.
- Out-of-range write (index ≥ limit in either field): no state changes and out_err is set. out_err stays set until in_err_clr is asserted.
- If set and in_err_clr occur in the same cycle, set wins.
- FSM states: IDLE, PENDING, COMMIT.
  - IDLE: in_commit & !in_busy → COMMIT; in_commit & in_busy → PENDING.
  - PENDING: !in_busy → COMMIT; otherwise stay. Further in_commit pulses are absorbed.
  - COMMIT: every active mask is loaded from the registered shadow, and out_commit_done is set for the next cycle. Next state: in_commit & in_busy → PENDING; in_commit & !in_busy → COMMIT again; otherwise IDLE.
- out_commit_pending = (state == PENDING).
- A write issued while the FSM is in COMMIT goes into the shadow only. It is not in the active copy until another commit.
- A write and a commit in the same IDLE cycle: the write is included in that commit.
- Reset mid-PENDING or mid-COMMIT: the commit is discarded and all masks return to their reset values.

## Timing
- Write latency: shadow updated at the edge where in_we is sampled.
- Commit latency, in_commit sampled high at edge k with in_busy low: COMMIT occupies cycle k..k+1. out_masks and out_commit_done both change at edge k+1, and out_commit_done is high for exactly one cycle.
- Deferred commit: COMMIT is entered on the first edge that samples in_busy low.
- Readback latency: 1 cycle. out_rd_data and out_rd_valid are registered.
- Readback with a same-cycle write to the same byte returns the old value.

## Configuration
- MASK_BANK_READBACK_EN defined: in_rd_en returns the addressed shadow byte on out_rd_data one cycle later, with out_rd_valid high for one cycle. An out-of-range read returns 0x00 and sets out_err.
- MASK_BANK_READBACK_EN undefined: no readback logic is built. in_rd_en is ignored, and out_rd_data/out_rd_valid are tied to 0. Ports are unchanged.

## Structure
- Shared package dla_pkg holds:
  - commit FSM state enum (IDLE/PENDING/COMMIT);
  - DLA_BYTE_W = 8;
  - default NUM_MASKS and MASK_WIDTH;
  - a function returning the byte-lane count, MASK_WIDTH/8.
- One sub-module, mask_bank_slot: a single mask with shadow register, active register, byte-lane write decode and a commit-load input. It is instantiated NUM_MASKS times by generate.
- The commit FSM, error flag and readback mux stay in the top level.

## Test plan
- Reset, then read out_masks: mask 0 = 64'hFFFF_FFFF_FFFF_FFFF, masks 1–4 = 0; all other outputs are 0.
- Write P0=2, P1=3, P2=0xA5, then commit with in_busy=0. Before done, out_masks for mask 2 = 0. Two edges after the commit, out_masks for mask 2 = 64'h0000_0000_A500_0000, with out_commit_done pulsing once.
- Hold in_busy=1 and pulse commit. out_commit_pending stays high and out_masks is unchanged for 10 cycles. Drop in_busy: the active masks update one cycle later, followed by the done pulse.
- Write P0=5, P2=0x11 → no mask changes and out_err=1. Pulse in_err_clr → out_err=0. Write P1=8 → out_err=1 again.
- Write and commit in the same cycle (P0=1, P1=0, P2=0x3C) → the committed mask 1 = 64'h3C.
- With MASK_BANK_READBACK_EN: write P0=0, P1=7, P2=0x5A, then rd_en at P0=0/P1=7 → out_rd_data=0x5A, valid one cycle later. Assert in_rst_n low mid-PENDING → pending cleared, mask 0 = all ones.

Source files
------------

// File: rtl/dla_pkg.sv
// Shared definitions for the logic-analyzer mask bank: commit FSM states,
// byte width, default geometry and the byte-lane helper.
package dla_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StCommit
  } commit_state_e;

  localparam int unsigned DLA_BYTE_W     = 8;
  localparam int unsigned DEF_NUM_MASKS  = 5;
  localparam int unsigned DEF_MASK_WIDTH = 64;

  function automatic int unsigned lane_count(input int unsigned mask_width);
    return mask_width / DLA_BYTE_W;
  endfunction

endpackage

// File: rtl/mask_bank_slot.sv
// One double-buffered trigger mask: byte-addressed shadow register plus an
// active register that loads the whole shadow on a commit.
module mask_bank_slot
  import dla_pkg::*;
#(
  parameter int unsigned MASK_WIDTH = DEF_MASK_WIDTH,
  parameter bit          RST_ONES   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [7:0]            lane,
  input  logic [7:0]            wdata,
  input  logic                  load,
  output logic [MASK_WIDTH-1:0] shadow,
  output logic [MASK_WIDTH-1:0] active
);

  localparam int unsigned LANES = lane_count(MASK_WIDTH);
  localparam logic [MASK_WIDTH-1:0] RST_VAL = {MASK_WIDTH{RST_ONES}};

  logic [MASK_WIDTH-1:0] shadow_q, shadow_d;
  logic [MASK_WIDTH-1:0] active_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int l = 0; l < LANES; l++) begin
      if (we && lane == 8'(l)) begin
        shadow_d[l*DLA_BYTE_W +: DLA_BYTE_W] = wdata;
      end
    end
  end

  // Active loads the registered shadow, so a write landing on the load edge waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
    end else begin
      shadow_q <= shadow_d;
      if (load) begin
        active_q <= shadow_q;
      end
    end
  end

  assign shadow = shadow_q;
  assign active = active_q;

endmodule

// File: rtl/mask_bank.sv
// Trigger-mask register bank with byte writes, busy-deferred atomic commit and
// sticky range error. Shadow readback is built only with MASK_BANK_READBACK_EN.
module mask_bank
  import dla_pkg::*;
#(
  parameter int unsigned NUM_MASKS  = DEF_NUM_MASKS,
  parameter int unsigned MASK_WIDTH = DEF_MASK_WIDTH
) (
  input  logic                            in_clk,
  input  logic                            in_rst_n,
  input  logic                            in_we,
  input  logic [7:0]                      in_P0,
  input  logic [7:0]                      in_P1,
  input  logic [7:0]                      in_P2,
  input  logic                            in_commit,
  input  logic                            in_busy,
  input  logic                            in_err_clr,
  input  logic                            in_rd_en,
  output logic [NUM_MASKS*MASK_WIDTH-1:0] out_masks,
  output logic                            out_commit_pending,
  output logic                            out_commit_done,
  output logic                            out_err,
  output logic [7:0]                      out_rd_data,
  output logic                            out_rd_valid
);

  localparam int unsigned LANES = lane_count(MASK_WIDTH);

  logic addr_ok, wr_ok, wr_oor, rd_oor;
  logic commit_load;
  logic done_q, err_q, err_d;
  logic [NUM_MASKS*MASK_WIDTH-1:0] shadow_all;
  commit_state_e state_q, state_d;

  assign addr_ok = (32'(in_P0) < NUM_MASKS) && (32'(in_P1) < LANES);
  assign wr_ok   = in_we && addr_ok;
  assign wr_oor  = in_we && !addr_ok;

  for (genvar m = 0; m < NUM_MASKS; m++) begin : g_slot
    logic slot_we;
    assign slot_we = wr_ok && (in_P0 == 8'(m));

    mask_bank_slot #(
      .MASK_WIDTH(MASK_WIDTH),
      .RST_ONES  (m == 0)
    ) u_slot (
      .clk   (in_clk),
      .rst_n (in_rst_n),
      .we    (slot_we),
      .lane  (in_P1),
      .wdata (in_P2),
      .load  (commit_load),
      .shadow(shadow_all[m*MASK_WIDTH +: MASK_WIDTH]),
      .active(out_masks[m*MASK_WIDTH +: MASK_WIDTH])
    );
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_commit) state_d = in_busy ? StPending : StCommit;
      end
      StPending: begin
        if (!in_busy) state_d = StCommit;
      end
      StCommit: begin
        if (in_commit) state_d = in_busy ? StPending : StCommit;
        else           state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    commit_load        = (state_q == StCommit);
    out_commit_pending = (state_q == StPending);
  end

  // A new error in the same cycle as a clear takes priority.
  assign err_d = (err_q && !in_err_clr) || wr_oor || rd_oor;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= commit_load;
      err_q  <= err_d;
    end
  end

  assign out_commit_done = done_q;
  assign out_err         = err_q;

`ifdef MASK_BANK_READBACK_EN
  logic [7:0] rd_byte, rd_data_q;
  logic       rd_valid_q;

  always_comb begin
    rd_byte = '0;
    for (int m = 0; m < NUM_MASKS; m++) begin
      for (int l = 0; l < LANES; l++) begin
        if (in_P0 == 8'(m) && in_P1 == 8'(l)) begin
          rd_byte = shadow_all[m*MASK_WIDTH + l*DLA_BYTE_W +: DLA_BYTE_W];
        end
      end
    end
  end

  assign rd_oor = in_rd_en && !addr_ok;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= in_rd_en ? rd_byte : 8'h00;
      rd_valid_q <= in_rd_en;
    end
  end

  assign out_rd_data  = rd_data_q;
  assign out_rd_valid = rd_valid_q;
`else
  logic unused_readback;
  assign unused_readback = in_rd_en ^ (^shadow_all);
  assign rd_oor          = 1'b0;
  assign out_rd_data     = 8'h00;
  assign out_rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_mask_bank.sv
// Directed plus randomized checks of mask_bank against a byte-array reference model.
module tb_mask_bank;

  localparam int unsigned NM = 5;
  localparam int unsigned MW = 64;
  localparam int unsigned LN = MW / 8;

`ifdef MASK_BANK_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic we = 1'b0, commit = 1'b0, busy = 1'b0, err_clr = 1'b0, rd_en = 1'b0;
  logic [7:0] p0 = '0, p1 = '0, p2 = '0;
  logic [NM*MW-1:0] masks;
  logic pending, done, err, rd_valid;
  logic [7:0] rd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mask_bank #(
    .NUM_MASKS (NM),
    .MASK_WIDTH(MW)
  ) dut (
    .in_clk            (clk),
    .in_rst_n          (rst_n),
    .in_we             (we),
    .in_P0             (p0),
    .in_P1             (p1),
    .in_P2             (p2),
    .in_commit         (commit),
    .in_busy           (busy),
    .in_err_clr        (err_clr),
    .in_rd_en          (rd_en),
    .out_masks         (masks),
    .out_commit_pending(pending),
    .out_commit_done   (done),
    .out_err           (err),
    .out_rd_data       (rd_data),
    .out_rd_valid      (rd_valid)
  );

  // Reference model: per-byte shadow/active arrays and commit bookkeeping.
  logic [7:0] sh [NM][LN];
  logic [7:0] ac [NM][LN];
  bit load_sched, waiting, err_m, done_m, rdv_m;
  logic [7:0] rdd_m;

  function automatic void model_reset();
    for (int m = 0; m < NM; m++)
      for (int l = 0; l < LN; l++) begin
        sh[m][l] = (m == 0) ? 8'hFF : 8'h00;
        ac[m][l] = sh[m][l];
      end
    load_sched = 0; waiting = 0; err_m = 0; done_m = 0; rdv_m = 0; rdd_m = 8'h00;
  endfunction

  function automatic void model_edge();
    bit ok, want;
    ok = (p0 < NM) && (p1 < LN);
    done_m = load_sched;
    if (load_sched) ac = sh;
    if (RB) begin
      rdv_m = rd_en;
      rdd_m = (rd_en && ok) ? sh[p0][p1] : 8'h00;
    end
    err_m = (err_m && !err_clr) || (we && !ok) || (RB && rd_en && !ok);
    if (we && ok) sh[p0][p1] = p2;
    want = waiting || commit;
    load_sched = want && !busy;
    waiting = want && busy;
  endfunction

  task automatic chk(input string tag, input logic [NM*MW-1:0] got,
                     input logic [NM*MW-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NM*MW-1:0] exp;
    for (int m = 0; m < NM; m++)
      for (int l = 0; l < LN; l++) exp[m*MW + l*8 +: 8] = ac[m][l];
    chk({tag, ".masks"}, masks, exp);
    chk({tag, ".pending"}, (NM*MW)'(pending), (NM*MW)'(waiting));
    chk({tag, ".done"}, (NM*MW)'(done), (NM*MW)'(done_m));
    chk({tag, ".err"}, (NM*MW)'(err), (NM*MW)'(err_m));
    chk({tag, ".rd_data"}, (NM*MW)'(rd_data), (NM*MW)'(rdd_m));
    chk({tag, ".rd_valid"}, (NM*MW)'(rd_valid), (NM*MW)'(rdv_m));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic quiet();
    we = 0; commit = 0; err_clr = 0; rd_en = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    chk("reset.mask0", (NM*MW)'(masks[MW-1:0]), (NM*MW)'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("reset.mask1_4", (NM*MW)'(masks[NM*MW-1:MW]), '0);
    rst_n = 1;
    tick("idle");

    we = 1; p0 = 2; p1 = 3; p2 = 8'hA5;
    tick("wr_m2");
    quiet(); commit = 1;
    tick("commit_k");
    chk("commit_k.mask2", (NM*MW)'(masks[2*MW +: MW]), '0);
    quiet();
    tick("commit_k1");
    chk("commit_k1.mask2", (NM*MW)'(masks[2*MW +: MW]), (NM*MW)'(64'h0000_0000_A500_0000));
    chk("commit_k1.done", (NM*MW)'(done), (NM*MW)'(1'b1));
    tick("commit_k2");
    chk("commit_k2.done", (NM*MW)'(done), '0);

    we = 1; p0 = 3; p1 = 0; p2 = 8'h77;
    tick("wr_m3");
    quiet(); busy = 1; commit = 1;
    tick("busy_req");
    quiet();
    for (int i = 0; i < 10; i++) begin
      tick("busy_hold");
      chk("busy_hold.pending", (NM*MW)'(pending), (NM*MW)'(1'b1));
      chk("busy_hold.mask3", (NM*MW)'(masks[3*MW +: MW]), '0);
    end
    busy = 0;
    tick("busy_drop");
    tick("deferred_load");
    chk("deferred.mask3", (NM*MW)'(masks[3*MW +: MW]), (NM*MW)'(64'h77));
    tick("deferred_after");

    we = 1; p0 = 5; p1 = 0; p2 = 8'h11;
    tick("oor_p0");
    chk("oor_p0.err", (NM*MW)'(err), (NM*MW)'(1'b1));
    quiet(); err_clr = 1;
    tick("err_clr");
    chk("err_clr.err", (NM*MW)'(err), '0);
    quiet(); we = 1; p0 = 0; p1 = 8;
    tick("oor_p1");
    chk("oor_p1.err", (NM*MW)'(err), (NM*MW)'(1'b1));
    quiet(); err_clr = 1; we = 1; p0 = 9;
    tick("set_and_clr");
    quiet(); err_clr = 1;
    tick("err_clr2");

    we = 1; p0 = 1; p1 = 0; p2 = 8'h3C; commit = 1;
    tick("wr_commit");
    quiet();
    tick("wr_commit_load");
    chk("wr_commit.mask1", (NM*MW)'(masks[MW +: MW]), (NM*MW)'(64'h3C));

    we = 1; p0 = 0; p1 = 7; p2 = 8'h5A;
    tick("wr_m0");
    quiet(); rd_en = 1; p0 = 0; p1 = 7;
    tick("readback");
`ifdef MASK_BANK_READBACK_EN
    chk("readback.data", (NM*MW)'(rd_data), (NM*MW)'(8'h5A));
    chk("readback.valid", (NM*MW)'(rd_valid), (NM*MW)'(1'b1));
`endif
    quiet(); busy = 1; commit = 1;
    tick("pend_req");
    quiet();
    tick("pend_hold");
    @(negedge clk);
    rst_n = 0;
    #2;
    model_reset();
    check_all("rst_pending");
    chk("rst_pending.mask0", (NM*MW)'(masks[MW-1:0]), (NM*MW)'(64'hFFFF_FFFF_FFFF_FFFF));
    rst_n = 1; busy = 0;
    tick("post_rst");

    for (int i = 0; i < 300; i++) begin
      we      = ($urandom_range(0, 99) < 50);
      p0      = 8'($urandom_range(0, 6));
      p1      = 8'($urandom_range(0, 9));
      p2      = 8'($urandom);
      commit  = ($urandom_range(0, 99) < 25);
      busy    = ($urandom_range(0, 99) < 30);
      err_clr = ($urandom_range(0, 99) < 10);
      rd_en   = ($urandom_range(0, 99) < 30);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
